// File: rtl/tron_pkg.sv
// Shared types and constants for the trail-collision reader: grid geometry,
// VRAM colour words, verdict encoding and checker FSM states.
package tron_pkg;

   localparam int unsigned GRID_DIM   = 75;
   localparam int unsigned CELL_SHIFT = 3;

   localparam logic [23:0] COLOR_EMPTY = 24'h000000;
   localparam logic [23:0] COLOR_P1    = 24'h0000FF;
   localparam logic [23:0] COLOR_P2    = 24'hFF0000;

   // Encoded as the surviving player: a lone p1 crash means p2 wins.
   typedef enum logic [1:0] {
      W_NONE = 2'b00,
      W_P1   = 2'b01,
      W_P2   = 2'b10,
      W_DRAW = 2'b11
   } winner_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_P1  = 3'd1,
      S_RD_P2  = 3'd2,
      S_WAIT   = 3'd3,
      S_DECIDE = 3'd4,
      S_OVER   = 3'd5
   } state_t;

endpackage

// File: rtl/pix_to_cell.sv
// Maps a pixel position to its grid cell and flags positions outside the play field.
module pix_to_cell #(
   parameter int unsigned BORDER_OFFSET = 100,
   parameter int unsigned FIELD_W       = 600,
   parameter int unsigned FIELD_H       = 600,
   parameter int unsigned CELL_SHIFT    = tron_pkg::CELL_SHIFT
) (
   input  logic [9:0] px,
   input  logic [9:0] py,
   output logic [6:0] cx,
   output logic [6:0] cy,
   output logic       oob
);

   logic [9:0] rel_x_s;

   // Left-of-border positions wrap here; oob covers them, the cell is don't-care.
   assign rel_x_s = px - 10'(BORDER_OFFSET);
   assign cx      = 7'(rel_x_s >> CELL_SHIFT);
   assign cy      = 7'(py >> CELL_SHIFT);
   assign oob     = (px < 10'(BORDER_OFFSET))
                  | (px >= 10'(BORDER_OFFSET + FIELD_W))
                  | (py >= 10'(FIELD_H));

endmodule

// File: rtl/trail_collision_checker.sv
// Once per frame reads both trail VRAMs at each player's next cell and
// registers crash verdicts, winner and the sticky game_over flag.
module trail_collision_checker
   import tron_pkg::*;
#(
   parameter int unsigned BORDER_OFFSET = 100,
   parameter int unsigned FIELD_W       = 600,
   parameter int unsigned FIELD_H       = 600,
   parameter int unsigned CELL_SHIFT    = tron_pkg::CELL_SHIFT,
   parameter int unsigned DATA_W        = 24
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              frame_tick,
   input  logic              round_start,
   input  logic [9:0]        p1_x,
   input  logic [9:0]        p1_y,
   input  logic [9:0]        p2_x,
   input  logic [9:0]        p2_y,
   input  logic [9:0]        p1_nx,
   input  logic [9:0]        p1_ny,
   input  logic [9:0]        p2_nx,
   input  logic [9:0]        p2_ny,
   output logic              mem_rd_en,
   output logic [6:0]        mem_rd_x,
   output logic [6:0]        mem_rd_y,
   input  logic [DATA_W-1:0] p1_mem_dout,
   input  logic [DATA_W-1:0] p2_mem_dout,
   output logic              busy,
   output logic              result_valid,
   output logic              p1_crash,
   output logic              p2_crash,
   output logic [1:0]        winner,
   output logic              game_over,
   output logic              move_allow
);

   function automatic logic word_occupied(input logic [DATA_W-1:0] w);
      return (w != {DATA_W{1'b0}});
   endfunction

   state_t     state_r;
   winner_t    winner_r;
   logic [9:0] p1_x_r, p1_y_r, p2_x_r, p2_y_r;
   logic [9:0] p1_nx_r, p1_ny_r, p2_nx_r, p2_ny_r;
   logic       occ1_r, occ2_r;
   logic       busy_r, result_valid_r, p1_crash_r, p2_crash_r, game_over_r, move_allow_r;

   logic [6:0] c1_cx_s, c1_cy_s, c2_cx_s, c2_cy_s;
   logic [6:0] n1_cx_s, n1_cy_s, n2_cx_s, n2_cy_s;
   logic       c1_oob_s, c2_oob_s, n1_oob_s, n2_oob_s;
   logic       same1_s, same2_s, head_on_s, crash1_s, crash2_s;
   winner_t    winner_s;

   pix_to_cell #(.BORDER_OFFSET(BORDER_OFFSET), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .CELL_SHIFT(CELL_SHIFT))
      u_p1_cur (.px(p1_x_r), .py(p1_y_r), .cx(c1_cx_s), .cy(c1_cy_s), .oob(c1_oob_s));
   pix_to_cell #(.BORDER_OFFSET(BORDER_OFFSET), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .CELL_SHIFT(CELL_SHIFT))
      u_p2_cur (.px(p2_x_r), .py(p2_y_r), .cx(c2_cx_s), .cy(c2_cy_s), .oob(c2_oob_s));
   pix_to_cell #(.BORDER_OFFSET(BORDER_OFFSET), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .CELL_SHIFT(CELL_SHIFT))
      u_p1_nxt (.px(p1_nx_r), .py(p1_ny_r), .cx(n1_cx_s), .cy(n1_cy_s), .oob(n1_oob_s));
   pix_to_cell #(.BORDER_OFFSET(BORDER_OFFSET), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .CELL_SHIFT(CELL_SHIFT))
      u_p2_nxt (.px(p2_nx_r), .py(p2_ny_r), .cx(n2_cx_s), .cy(n2_cy_s), .oob(n2_oob_s));

   // Read port drive: one address per read state, idle otherwise.
   always_comb begin
      mem_rd_en = 1'b0;
      mem_rd_x  = 7'd0;
      mem_rd_y  = 7'd0;
      case (state_r)
         S_RD_P1: begin
            mem_rd_en = 1'b1;
            mem_rd_x  = n1_cx_s;
            mem_rd_y  = n1_cy_s;
         end
         S_RD_P2: begin
            mem_rd_en = 1'b1;
            mem_rd_x  = n2_cx_s;
            mem_rd_y  = n2_cy_s;
         end
         default: begin
            mem_rd_en = 1'b0;
         end
      endcase
   end

   // Verdict logic: a player's own trail under its head is exempt while it stays in its cell.
   always_comb begin
      same1_s   = (c1_cx_s == n1_cx_s) && (c1_cy_s == n1_cy_s);
      same2_s   = (c2_cx_s == n2_cx_s) && (c2_cy_s == n2_cy_s);
      head_on_s = (n1_cx_s == n2_cx_s) && (n1_cy_s == n2_cy_s) && !n1_oob_s && !n2_oob_s;
      crash1_s  = n1_oob_s | (occ1_r & ~same1_s) | head_on_s;
      crash2_s  = n2_oob_s | (occ2_r & ~same2_s) | head_on_s;
      case ({crash1_s, crash2_s})
         2'b10:   winner_s = W_P2;
         2'b01:   winner_s = W_P1;
         2'b11:   winner_s = W_DRAW;
         default: winner_s = W_NONE;
      endcase
   end

   // Check sequencer with registered verdict and status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= S_IDLE;
         winner_r       <= W_NONE;
         p1_x_r         <= 10'd0;
         p1_y_r         <= 10'd0;
         p2_x_r         <= 10'd0;
         p2_y_r         <= 10'd0;
         p1_nx_r        <= 10'd0;
         p1_ny_r        <= 10'd0;
         p2_nx_r        <= 10'd0;
         p2_ny_r        <= 10'd0;
         occ1_r         <= 1'b0;
         occ2_r         <= 1'b0;
         busy_r         <= 1'b0;
         result_valid_r <= 1'b0;
         p1_crash_r     <= 1'b0;
         p2_crash_r     <= 1'b0;
         game_over_r    <= 1'b0;
         move_allow_r   <= 1'b1;
      end else if (round_start) begin
         state_r        <= S_IDLE;
         winner_r       <= W_NONE;
         busy_r         <= 1'b0;
         result_valid_r <= 1'b0;
         p1_crash_r     <= 1'b0;
         p2_crash_r     <= 1'b0;
         game_over_r    <= 1'b0;
         move_allow_r   <= 1'b1;
      end else begin
         result_valid_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (frame_tick) begin
                  p1_x_r  <= p1_x;
                  p1_y_r  <= p1_y;
                  p2_x_r  <= p2_x;
                  p2_y_r  <= p2_y;
                  p1_nx_r <= p1_nx;
                  p1_ny_r <= p1_ny;
                  p2_nx_r <= p2_nx;
                  p2_ny_r <= p2_ny;
                  busy_r  <= 1'b1;
                  state_r <= S_RD_P1;
               end
            end
            S_RD_P1: state_r <= S_RD_P2;
            S_RD_P2: begin
               // Data returned now belongs to the p1 address issued last cycle.
               occ1_r  <= word_occupied(p1_mem_dout) | word_occupied(p2_mem_dout);
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               occ2_r  <= word_occupied(p1_mem_dout) | word_occupied(p2_mem_dout);
               state_r <= S_DECIDE;
            end
            S_DECIDE: begin
               p1_crash_r     <= crash1_s;
               p2_crash_r     <= crash2_s;
               winner_r       <= winner_s;
               result_valid_r <= 1'b1;
               busy_r         <= 1'b0;
               if (crash1_s || crash2_s) begin
                  game_over_r  <= 1'b1;
                  move_allow_r <= 1'b0;
                  state_r      <= S_OVER;
               end else begin
                  state_r      <= S_IDLE;
               end
            end
            S_OVER:  state_r <= S_OVER;
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_r;
   assign result_valid = result_valid_r;
   assign p1_crash     = p1_crash_r;
   assign p2_crash     = p2_crash_r;
   assign winner       = winner_r;
   assign game_over    = game_over_r;
   assign move_allow   = move_allow_r;

endmodule

// File: tb/tb_trail_collision_checker.sv
// Directed and randomized checks of trail_collision_checker against a pixel-level reference.
module tb_trail_collision_checker;

   logic        clock = 1'b0;
   logic        reset_n, frame_tick, round_start;
   logic [9:0]  p1_x, p1_y, p2_x, p2_y, p1_nx, p1_ny, p2_nx, p2_ny;
   logic        mem_rd_en;
   logic [6:0]  mem_rd_x, mem_rd_y;
   logic [23:0] p1_mem_dout = 24'h0, p2_mem_dout = 24'h0;
   logic        busy, result_valid, p1_crash, p2_crash, game_over, move_allow;
   logic [1:0]  winner;

   logic [23:0] m1 [0:16383];
   logic [23:0] m2 [0:16383];
   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   trail_collision_checker dut (
      .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .round_start(round_start),
      .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
      .p1_nx(p1_nx), .p1_ny(p1_ny), .p2_nx(p2_nx), .p2_ny(p2_ny),
      .mem_rd_en(mem_rd_en), .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y),
      .p1_mem_dout(p1_mem_dout), .p2_mem_dout(p2_mem_dout),
      .busy(busy), .result_valid(result_valid), .p1_crash(p1_crash), .p2_crash(p2_crash),
      .winner(winner), .game_over(game_over), .move_allow(move_allow)
   );

   // VRAM model: registered read, data valid the cycle after the address.
   always @(posedge clock) begin
      if (mem_rd_en) begin
         p1_mem_dout <= m1[{mem_rd_y, mem_rd_x}];
         p2_mem_dout <= m2[{mem_rd_y, mem_rd_x}];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic int cell_idx(input int x, input int y);
      int cx, cy;
      cx = (((x - 100 + 1024) % 1024) / 8) % 128;
      cy = (y / 8) % 128;
      return cy * 128 + cx;
   endfunction

   function automatic bit ref_oob(input int x, input int y);
      return (x < 100) || (x >= 700) || (y >= 600);
   endfunction

   task automatic clear_mem();
      foreach (m1[i]) begin
         m1[i] = 24'h0;
         m2[i] = 24'h0;
      end
   endtask

   task automatic set_pos(input int ax, ay, anx, any, bx, by, bnx, bny);
      p1_x = 10'(ax);  p1_y = 10'(ay);  p1_nx = 10'(anx); p1_ny = 10'(any);
      p2_x = 10'(bx);  p2_y = 10'(by);  p2_nx = 10'(bnx); p2_ny = 10'(bny);
   endtask

   task automatic pulse_round_start();
      @(posedge clock); #1 round_start = 1'b1;
      @(posedge clock); #1 round_start = 1'b0;
   endtask

   // Issues one frame_tick and watches ten cycles; k=0 is the cycle after the sampling edge.
   task automatic run_check(output int lat, output int pulses, output int reads, output logic [9:0] busy_mask);
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      lat = -1; pulses = 0; reads = 0; busy_mask = 10'd0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         busy_mask[k] = busy;
         if (mem_rd_en === 1'b1) reads++;
         if (result_valid === 1'b1) begin
            pulses++;
            if (lat < 0) lat = k;
         end
      end
   endtask

   task automatic ref_model(output logic c1, output logic c2, output logic [1:0] w);
      int n1, n2, k1, k2;
      bit o1, o2, occ1, occ2, head;
      o1 = ref_oob(int'(p1_nx), int'(p1_ny));
      o2 = ref_oob(int'(p2_nx), int'(p2_ny));
      n1 = cell_idx(int'(p1_nx), int'(p1_ny));
      n2 = cell_idx(int'(p2_nx), int'(p2_ny));
      k1 = cell_idx(int'(p1_x), int'(p1_y));
      k2 = cell_idx(int'(p2_x), int'(p2_y));
      occ1 = (m1[n1] != 24'h0) || (m2[n1] != 24'h0);
      occ2 = (m1[n2] != 24'h0) || (m2[n2] != 24'h0);
      head = (n1 == n2) && !o1 && !o2;
      c1 = o1 || (occ1 && (n1 != k1)) || head;
      c2 = o2 || (occ2 && (n2 != k2)) || head;
      if (c1 && c2)  w = 2'b11;
      else if (c1)   w = 2'b10;
      else if (c2)   w = 2'b01;
      else           w = 2'b00;
   endtask

   task automatic test_reset();
      int lat, pulses, reads;
      logic [9:0] bm;
      checks++;
      if ({busy, result_valid, p1_crash, p2_crash, winner, game_over, move_allow, mem_rd_en} !== 9'b0000_0000_1 << 1) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b", {busy, result_valid, p1_crash, p2_crash, winner, game_over, move_allow, mem_rd_en}, 9'b000000010);
      end
      // Reach game over, then drop reset between clock edges.
      clear_mem();
      set_pos(100, 300, 98, 300, 400, 0, 400, 1022);
      run_check(lat, pulses, reads, bm);
      checks++;
      if (game_over !== 1'b1) begin failures++; $display("FAIL reset_pre_over got=%b exp=1", game_over); end
      @(posedge clock); #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({p1_crash, p2_crash, winner, game_over, move_allow, result_valid} !== 7'b0000010) begin
         failures++;
         $display("FAIL reset_async_over got=%b exp=0000010", {p1_crash, p2_crash, winner, game_over, move_allow, result_valid});
      end
      @(negedge clock) reset_n = 1'b1;
      // Reset in the middle of a check.
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      checks++;
      if ({busy, mem_rd_en} !== 2'b11) begin failures++; $display("FAIL reset_pre_busy got=%b exp=11", {busy, mem_rd_en}); end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, mem_rd_en, mem_rd_x, mem_rd_y, move_allow} !== 17'b1) begin
         failures++;
         $display("FAIL reset_async_busy got=%b exp=%b", {busy, mem_rd_en, mem_rd_x, mem_rd_y, move_allow}, 17'b1);
      end
      @(negedge clock) reset_n = 1'b1;
   endtask

   task automatic test_same_cell();
      int lat, pulses, reads;
      logic [9:0] bm;
      clear_mem();
      set_pos(116, 575, 116, 573, 675, 16, 675, 18);
      run_check(lat, pulses, reads, bm);
      checks++;
      if (lat !== 4 || pulses !== 1) begin failures++; $display("FAIL same_latency got=%0d/%0d exp=4/1", lat, pulses); end
      checks++;
      if (bm !== 10'b0000001111 || reads !== 2) begin failures++; $display("FAIL same_busy got=%b/%0d exp=0000001111/2", bm, reads); end
      checks++;
      if ({p1_crash, p2_crash, winner, game_over, move_allow} !== 6'b000001) begin
         failures++; $display("FAIL same_verdict got=%b exp=000001", {p1_crash, p2_crash, winner, game_over, move_allow});
      end
      // Own trail under the head is exempt while staying in the cell.
      m1[cell_idx(116, 573)] = 24'h0000FF;
      m2[cell_idx(675, 18)]  = 24'hFF0000;
      run_check(lat, pulses, reads, bm);
      checks++;
      if ({p1_crash, p2_crash, winner, game_over} !== 5'b00000 || pulses !== 1) begin
         failures++; $display("FAIL same_exempt got=%b/%0d exp=00000/1", {p1_crash, p2_crash, winner, game_over}, pulses);
      end
   endtask

   task automatic test_trail_hit();
      int lat, pulses, reads;
      logic [9:0] bm;
      clear_mem();
      set_pos(195, 300, 200, 300, 400, 400, 402, 400);
      m2[37 * 128 + 12] = 24'hFF0000;
      run_check(lat, pulses, reads, bm);
      checks++;
      if ({p1_crash, p2_crash, winner, game_over, move_allow} !== 6'b101010 || lat !== 4) begin
         failures++; $display("FAIL hit_verdict got=%b lat=%0d exp=101010 lat=4", {p1_crash, p2_crash, winner, game_over, move_allow}, lat);
      end
      pulse_round_start();
      #1;
      checks++;
      if ({p1_crash, p2_crash, winner, game_over, move_allow} !== 6'b000001) begin
         failures++; $display("FAIL hit_clear got=%b exp=000001", {p1_crash, p2_crash, winner, game_over, move_allow});
      end
   endtask

   task automatic test_border();
      int lat, pulses, reads;
      logic [9:0] bm;
      clear_mem();
      set_pos(100, 300, 98, 300, 400, 0, 400, 1022);
      run_check(lat, pulses, reads, bm);
      checks++;
      if ({p1_crash, p2_crash, winner, game_over, move_allow} !== 6'b111110) begin
         failures++; $display("FAIL border_verdict got=%b exp=111110", {p1_crash, p2_crash, winner, game_over, move_allow});
      end
      run_check(lat, pulses, reads, bm);
      checks++;
      if (reads !== 0 || pulses !== 0 || bm !== 10'd0) begin
         failures++; $display("FAIL border_ignored_tick got=reads %0d pulses %0d busy %b exp=0 0 0", reads, pulses, bm);
      end
      checks++;
      if ({winner, game_over} !== 3'b111) begin failures++; $display("FAIL border_hold got=%b exp=111", {winner, game_over}); end
      pulse_round_start();
   endtask

   task automatic test_head_on();
      int lat, pulses, reads;
      logic [9:0] bm;
      clear_mem();
      set_pos(290, 300, 300, 300, 310, 300, 300, 300);
      run_check(lat, pulses, reads, bm);
      checks++;
      if ({p1_crash, p2_crash, winner, game_over} !== 5'b11111 || pulses !== 1) begin
         failures++; $display("FAIL headon_verdict got=%b/%0d exp=11111/1", {p1_crash, p2_crash, winner, game_over}, pulses);
      end
      pulse_round_start();
   endtask

   task automatic test_abort();
      int lat, pulses, reads;
      logic [9:0] bm;
      clear_mem();
      set_pos(116, 575, 116, 573, 675, 16, 675, 18);
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      @(posedge clock); #1 round_start = 1'b1;
      @(posedge clock); #1 round_start = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, game_over} !== 2'b00) begin failures++; $display("FAIL abort_busy got=%b exp=00", {busy, game_over}); end
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (result_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", pulses); end
      // round_start wins over a coincident frame_tick.
      @(posedge clock); #1 begin frame_tick = 1'b1; round_start = 1'b1; end
      @(posedge clock); #1 begin frame_tick = 1'b0; round_start = 1'b0; end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL abort_priority got=%b exp=0", busy); end
      run_check(lat, pulses, reads, bm);
      checks++;
      if (lat !== 4 || pulses !== 1 || reads !== 2) begin
         failures++; $display("FAIL abort_rerun got=lat %0d pulses %0d reads %0d exp=4 1 2", lat, pulses, reads);
      end
   endtask

   task automatic test_random();
      int lat, pulses, reads;
      logic [9:0] bm;
      logic c1, c2;
      logic [1:0] w;
      int ax, ay, bx, by, anx, any, bnx, bny;
      for (int t = 0; t < 40; t++) begin
         clear_mem();
         ax = $urandom_range(708, 92);
         ay = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 0) : $urandom_range(607, 0);
         bx = $urandom_range(708, 92);
         by = $urandom_range(607, 0);
         anx = (ax + $urandom_range(16, 0) - 8 + 1024) % 1024;
         any = (ay + $urandom_range(16, 0) - 8 + 1024) % 1024;
         bnx = (bx + $urandom_range(16, 0) - 8 + 1024) % 1024;
         bny = (by + $urandom_range(16, 0) - 8 + 1024) % 1024;
         if ($urandom_range(3, 0) == 0) begin
            bnx = anx;
            bny = any;
         end
         set_pos(ax, ay, anx, any, bx, by, bnx, bny);
         if ($urandom_range(2, 0) == 0) m1[cell_idx(anx, any)] = 24'($urandom_range(24'hFFFFFF, 1));
         if ($urandom_range(2, 0) == 0) m2[cell_idx(bnx, bny)] = 24'($urandom_range(24'hFFFFFF, 1));
         if ($urandom_range(2, 0) == 0) m2[cell_idx(ax, ay)]   = 24'($urandom_range(24'hFFFFFF, 1));
         if ($urandom_range(2, 0) == 0) m1[cell_idx(bx, by)]   = 24'($urandom_range(24'hFFFFFF, 1));
         ref_model(c1, c2, w);
         run_check(lat, pulses, reads, bm);
         checks++;
         if ({p1_crash, p2_crash, winner, game_over, move_allow} !== {c1, c2, w, c1 | c2, ~(c1 | c2)} || lat !== 4) begin
            failures++;
            $display("FAIL rand_%0d got=%b lat=%0d exp=%b lat=4 pos=(%0d,%0d)->(%0d,%0d) (%0d,%0d)->(%0d,%0d)", t,
                     {p1_crash, p2_crash, winner, game_over, move_allow}, lat,
                     {c1, c2, w, c1 | c2, ~(c1 | c2)}, ax, ay, anx, any, bx, by, bnx, bny);
         end
         pulse_round_start();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      frame_tick = 1'b0;
      round_start = 1'b0;
      set_pos(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      test_reset();
      test_same_cell();
      test_trail_hit();
      test_border();
      test_head_on();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
